// File: rtl/cop_sequencer_pkg.sv
// Shared definitions for the custom-0 opcode group.
// Contents:
//   ALU_* constants  - alu_ctrl encodings of the custom ops (also used by the decoder)
//   lane_op_t        - operation selector for the shared byte-lane unit
//   cop_state_t      - sequencer FSM states
//   is_cop_ctrl()    - true for an alu_ctrl value the sequencer accepts
//   lane_op_of()     - alu_ctrl to lane operation mapping
package cop_sequencer_pkg;

   localparam logic [3:0] ALU_RELU   = 4'h8;
   localparam logic [3:0] ALU_MATMUL = 4'h9;
   localparam logic [3:0] ALU_VECADD = 4'ha;
   localparam logic [3:0] ALU_MPOOL  = 4'hb;

   typedef enum logic [1:0] {
      LOP_RELU = 2'd0,
      LOP_ADD  = 2'd1,
      LOP_MUL  = 2'd2,
      LOP_MAX  = 2'd3
   } lane_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_WB   = 2'd3
   } cop_state_t;

   function automatic logic is_cop_ctrl(input logic [3:0] ctrl);
      case (ctrl)
         ALU_RELU, ALU_MATMUL, ALU_VECADD, ALU_MPOOL: is_cop_ctrl = 1'b1;
         default:                                    is_cop_ctrl = 1'b0;
      endcase
   endfunction

   function automatic lane_op_t lane_op_of(input logic [3:0] ctrl);
      case (ctrl)
         ALU_VECADD: lane_op_of = LOP_ADD;
         ALU_MATMUL: lane_op_of = LOP_MUL;
         ALU_MPOOL:  lane_op_of = LOP_MAX;
         default:    lane_op_of = LOP_RELU;
      endcase
   endfunction

endpackage

// File: rtl/cop_sequencer_if.sv
// Bundle of the sequencer's pipeline-side and lane-side signals.
// Groups:
//   flush                          - pipeline flush from the core
//   issue_* / stall                - decode-stage handshake
//   lane_*                         - request/result path to the shared byte-lane unit
//   wb_* / err                     - register writeback and timeout abort report
// Modports:
//   master - the sequencer itself
//   slave  - its environment (decode, lane unit, writeback)
interface cop_sequencer_if;
   import cop_sequencer_pkg::*;

   logic        flush;
   logic        issue_valid;
   logic [3:0]  issue_ctrl;
   logic [4:0]  issue_rd;
   logic [31:0] issue_a;
   logic [31:0] issue_b;
   logic        issue_ready;
   logic        stall;
   logic        lane_valid;
   lane_op_t    lane_op;
   logic [7:0]  lane_a;
   logic [7:0]  lane_b;
   logic        lane_ready;
   logic        lane_res_valid;
   logic [15:0] lane_res;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        err;

   modport master (
      input  flush, issue_valid, issue_ctrl, issue_rd, issue_a, issue_b,
      input  lane_ready, lane_res_valid, lane_res,
      output issue_ready, stall, lane_valid, lane_op, lane_a, lane_b,
      output wb_valid, wb_rd, wb_data, err
   );

   modport slave (
      output flush, issue_valid, issue_ctrl, issue_rd, issue_a, issue_b,
      output lane_ready, lane_res_valid, lane_res,
      input  issue_ready, stall, lane_valid, lane_op, lane_a, lane_b,
      input  wb_valid, wb_rd, wb_data, err
   );

endinterface

// File: rtl/cop_sequencer.sv
// Multi-cycle sequencer for the custom-0 ops (ReLU, MatMul, VecAdd, MPOOL).
// Takes one op from decode, stalls the pipeline, feeds the packed int8
// elements one at a time through the shared byte-lane unit, then issues a
// single register writeback.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - cop_sequencer_if.master (issue, lane and writeback signals)
// Every output is a flop loaded from the next-state values, so each output
// equals the decode of the current registered state and no input reaches an
// output combinationally.
module cop_sequencer
   import cop_sequencer_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   cop_sequencer_if.master bus
);

   localparam int IDX_W = $clog2(LANES);
   localparam int TMO_W = $clog2(TIMEOUT) + 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   cop_state_t       state_r, state_s;
   logic [3:0]       ctrl_r, ctrl_s;
   logic [4:0]       rd_r, rd_s;
   logic [31:0]      a_r, a_s;
   logic [31:0]      b_r, b_s;
   logic [31:0]      acc_r, acc_s;
   logic [31:0]      res_r, res_s;
   logic [IDX_W-1:0] idx_r, idx_s;
   logic [TMO_W-1:0] tmo_r, tmo_s;
   logic             abort_s;

   logic             issue_ready_r, issue_ready_s;
   logic             stall_r, stall_s;
   logic             lane_valid_r, lane_valid_s;
   lane_op_t         lane_op_r, lane_op_s;
   logic [7:0]       lane_a_r, lane_a_s;
   logic [7:0]       lane_b_r, lane_b_s;
   logic             wb_valid_r, wb_valid_s;
   logic [4:0]       wb_rd_r, wb_rd_s;
   logic [31:0]      wb_data_r, wb_data_s;
   logic             err_r;

   // Next-state, datapath update and next-output computation.
   always_comb begin
      state_s = state_r;
      ctrl_s  = ctrl_r;
      rd_s    = rd_r;
      a_s     = a_r;
      b_s     = b_r;
      acc_s   = acc_r;
      res_s   = res_r;
      idx_s   = idx_r;
      tmo_s   = tmo_r;
      abort_s = 1'b0;

      if (bus.flush) begin
         // Flush drops the op in flight, including a result arriving now.
         state_s = ST_IDLE;
         acc_s   = 32'h0000_0000;
         res_s   = 32'h0000_0000;
         idx_s   = '0;
         tmo_s   = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.issue_valid && is_cop_ctrl(bus.issue_ctrl)) begin
                  ctrl_s  = bus.issue_ctrl;
                  rd_s    = bus.issue_rd;
                  a_s     = bus.issue_a;
                  b_s     = bus.issue_b;
                  idx_s   = '0;
                  tmo_s   = '0;
                  res_s   = 32'h0000_0000;
                  // MPOOL starts from the smallest int8 so the first MAX keeps element 0.
                  acc_s   = (bus.issue_ctrl == ALU_MPOOL) ? 32'hFFFF_FF80 : 32'h0000_0000;
                  state_s = ST_SEND;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_SEND: begin
               if (bus.lane_ready) begin
                  tmo_s   = '0;
                  state_s = ST_WAIT;
               end else begin
                  state_s = ST_SEND;
               end
            end
            ST_WAIT: begin
               if (bus.lane_res_valid) begin
                  case (ctrl_r)
                     ALU_MATMUL: acc_s = acc_r + {{16{bus.lane_res[15]}}, bus.lane_res};
                     ALU_MPOOL:  acc_s = {{24{bus.lane_res[7]}}, bus.lane_res[7:0]};
                     default:    res_s[{idx_r, 3'b000} +: 8] = bus.lane_res[7:0];
                  endcase
                  if (idx_r == IDX_LAST) begin
                     state_s = ST_WB;
                  end else begin
                     idx_s   = idx_r + IDX_W'(1);
                     state_s = ST_SEND;
                  end
               end else if (tmo_r == TMO_LAST) begin
                  abort_s = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  tmo_s   = tmo_r + TMO_W'(1);
               end
            end
            ST_WB: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end

      issue_ready_s = (state_s == ST_IDLE);
      stall_s       = (state_s != ST_IDLE);
      lane_valid_s  = (state_s == ST_SEND);
      wb_valid_s    = (state_s == ST_WB);

      if (state_s == ST_SEND) begin
         lane_op_s = lane_op_of(ctrl_s);
         lane_a_s  = a_s[{idx_s, 3'b000} +: 8];
         case (ctrl_s)
            ALU_VECADD, ALU_MATMUL: lane_b_s = b_s[{idx_s, 3'b000} +: 8];
            ALU_MPOOL:              lane_b_s = acc_s[7:0];
            default:                lane_b_s = 8'h00;
         endcase
      end else begin
         lane_op_s = LOP_RELU;
         lane_a_s  = 8'h00;
         lane_b_s  = 8'h00;
      end

      if (state_s == ST_WB) begin
         wb_rd_s   = rd_s;
         wb_data_s = (ctrl_s == ALU_MATMUL || ctrl_s == ALU_MPOOL) ? acc_s : res_s;
      end else begin
         wb_rd_s   = 5'd0;
         wb_data_s = 32'h0000_0000;
      end
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         ctrl_r        <= 4'h0;
         rd_r          <= 5'd0;
         a_r           <= 32'h0000_0000;
         b_r           <= 32'h0000_0000;
         acc_r         <= 32'h0000_0000;
         res_r         <= 32'h0000_0000;
         idx_r         <= '0;
         tmo_r         <= '0;
         issue_ready_r <= 1'b1;
         stall_r       <= 1'b0;
         lane_valid_r  <= 1'b0;
         lane_op_r     <= LOP_RELU;
         lane_a_r      <= 8'h00;
         lane_b_r      <= 8'h00;
         wb_valid_r    <= 1'b0;
         wb_rd_r       <= 5'd0;
         wb_data_r     <= 32'h0000_0000;
         err_r         <= 1'b0;
      end else begin
         state_r       <= state_s;
         ctrl_r        <= ctrl_s;
         rd_r          <= rd_s;
         a_r           <= a_s;
         b_r           <= b_s;
         acc_r         <= acc_s;
         res_r         <= res_s;
         idx_r         <= idx_s;
         tmo_r         <= tmo_s;
         issue_ready_r <= issue_ready_s;
         stall_r       <= stall_s;
         lane_valid_r  <= lane_valid_s;
         lane_op_r     <= lane_op_s;
         lane_a_r      <= lane_a_s;
         lane_b_r      <= lane_b_s;
         wb_valid_r    <= wb_valid_s;
         wb_rd_r       <= wb_rd_s;
         wb_data_r     <= wb_data_s;
         err_r         <= abort_s;
      end
   end

   assign bus.issue_ready = issue_ready_r;
   assign bus.stall       = stall_r;
   assign bus.lane_valid  = lane_valid_r;
   assign bus.lane_op     = lane_op_r;
   assign bus.lane_a      = lane_a_r;
   assign bus.lane_b      = lane_b_r;
   assign bus.wb_valid    = wb_valid_r;
   assign bus.wb_rd       = wb_rd_r;
   assign bus.wb_data     = wb_data_r;
   assign bus.err         = err_r;

endmodule

// File: tb/tb_cop_sequencer.sv
// Directed self-checking bench for cop_sequencer. Includes a behavioural
// byte-lane unit (configurable ready delay, and one element whose result can
// be withheld) driven on the falling clock edge.
module tb_cop_sequencer;
   import cop_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   cop_sequencer_if bus ();

   cop_sequencer #(.LANES(4), .TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Lane-unit model configuration and request log.
   int         ready_delay = 0;
   int         hold_elem   = -1;
   lane_op_t   op_seen [4];
   logic [7:0] a_seen  [4];
   logic [7:0] b_seen  [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lane_calc(input lane_op_t op, input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sa;
      logic signed [15:0] sb;
      logic [7:0]         s8;
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      s8 = a + b;
      case (op)
         LOP_RELU: lane_calc = a[7] ? 16'h0000 : sa;
         LOP_ADD:  lane_calc = {{8{s8[7]}}, s8};
         LOP_MUL:  lane_calc = sa * sb;
         LOP_MAX:  lane_calc = (sa > sb) ? sa : sb;
         default:  lane_calc = 16'h0000;
      endcase
   endfunction

   // Byte-lane unit model: ready after ready_delay cycles, result one cycle later.
   initial begin : lane_model
      int          rdy_cnt;
      int          res_cnt;
      int          elem;
      bit          pending;
      logic [15:0] res_val;
      rdy_cnt = 0; res_cnt = 0; elem = 0; pending = 1'b0; res_val = 16'h0000;
      bus.lane_ready = 1'b0; bus.lane_res_valid = 1'b0; bus.lane_res = 16'h0000;
      forever begin
         @(negedge clk);
         bus.lane_ready     = 1'b0;
         bus.lane_res_valid = 1'b0;
         if (bus.stall !== 1'b1) begin
            pending = 1'b0; elem = 0; rdy_cnt = 0;
         end else if (pending) begin
            if (res_cnt == 0) begin
               bus.lane_res_valid = 1'b1;
               bus.lane_res       = res_val;
               pending            = 1'b0;
            end else begin
               res_cnt--;
            end
         end else if (bus.lane_valid === 1'b1) begin
            if (rdy_cnt >= ready_delay) begin
               bus.lane_ready = 1'b1;
               rdy_cnt = 0;
               if (elem < 4) begin
                  op_seen[elem] = bus.lane_op;
                  a_seen[elem]  = bus.lane_a;
                  b_seen[elem]  = bus.lane_b;
               end
               res_val = lane_calc(bus.lane_op, bus.lane_a, bus.lane_b);
               res_cnt = (elem == hold_elem) ? 1000 : 0;
               pending = 1'b1;
               elem++;
            end else begin
               rdy_cnt++;
            end
         end
      end
   end

   // Issue one op and wait (bounded) for its writeback; cycle 0 = issue cycle.
   task automatic run_op(input logic [3:0] ctrl, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output logic [4:0] wbrd,
                         output int cyc, output int stall_cnt);
      bit got;
      data = 32'hDEAD_BEEF; wbrd = 5'h1F; got = 1'b0; stall_cnt = 0;
      @(negedge clk);
      bus.issue_valid = 1'b1; bus.issue_ctrl = ctrl; bus.issue_rd = rd;
      bus.issue_a = a; bus.issue_b = b;
      @(negedge clk);
      bus.issue_valid = 1'b0;
      cyc = 1;
      while (!got && cyc < 60) begin
         if (bus.stall === 1'b1) stall_cnt++;
         if (bus.wb_valid === 1'b1) begin
            got = 1'b1; data = bus.wb_data; wbrd = bus.wb_rd;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   // Global time bound.
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Directed test sequence.
   initial begin : main
      logic [31:0] d;
      logic [4:0]  wrd;
      int          cyc, stall_cnt, wb_cnt, err_cnt, err_cyc;

      reset = 1'b1;
      bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_ctrl = 4'h0;
      bus.issue_rd = 5'd0; bus.issue_a = 32'h0; bus.issue_b = 32'h0;
      @(negedge clk);
      check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
      check("rst_stall",       32'(bus.stall),       32'd0);
      check("rst_lane_valid",  32'(bus.lane_valid),  32'd0);
      check("rst_wb_valid",    32'(bus.wb_valid),    32'd0);
      check("rst_wb_data",     bus.wb_data,          32'h0);
      check("rst_err",         32'(bus.err),         32'd0);
      reset = 1'b0;

      // VecAdd: 10+10=20, FF+01=00, 01+01=02, 7F+01=80.
      run_op(ALU_VECADD, 5'd3, 32'h7F01_FF10, 32'h0101_0110, d, wrd, cyc, stall_cnt);
      check("vadd_cycle", 32'(cyc),       32'd9);
      check("vadd_data",  d,              32'h8002_0020);
      check("vadd_rd",    32'(wrd),       32'd3);
      check("vadd_stall", 32'(stall_cnt), 32'd9);
      @(negedge clk);
      check("vadd_after_stall", 32'(bus.stall),       32'd0);
      check("vadd_after_ready", 32'(bus.issue_ready), 32'd1);
      check("vadd_after_wb",    32'(bus.wb_valid),    32'd0);

      // ReLU: 01->01, FF->00, 7F->7F, 80->00.
      run_op(ALU_RELU, 5'd7, 32'h807F_FF01, 32'hFFFF_FFFF, d, wrd, cyc, stall_cnt);
      check("relu_data",  d,         32'h007F_0001);
      check("relu_rd",    32'(wrd),  32'd7);
      check("relu_first", 32'(a_seen[0]), 32'h01);
      for (int i = 0; i < 4; i++) begin
         check("relu_op", 32'(op_seen[i]), 32'(LOP_RELU));
         check("relu_b",  32'(b_seen[i]),  32'h00);
      end

      // MatMul: 4+3+2+1 = 10.
      run_op(ALU_MATMUL, 5'd10, 32'h0102_0304, 32'h0101_0101, d, wrd, cyc, stall_cnt);
      check("mm1_data",  d,          32'h0000_000A);
      check("mm1_cycle", 32'(cyc),   32'd9);
      check("mm1_op",    32'(op_seen[0]), 32'(LOP_MUL));
      // MatMul, slow lane ready: 3*5 + (-2)*4 + 2*3 + (-1)*2 = 15-8+6-2 = 11.
      ready_delay = 2;
      run_op(ALU_MATMUL, 5'd11, 32'hFF02_FE03, 32'h0203_0405, d, wrd, cyc, stall_cnt);
      check("mm2_data",  d,          32'h0000_000B);
      check("mm2_cycle", 32'(cyc),   32'd17);
      ready_delay = 0;

      // MPOOL: max(03,05,FE,80) = 5; max(FD,FE,FF,80) = -1.
      run_op(ALU_MPOOL, 5'd12, 32'h80FE_0503, 32'h0, d, wrd, cyc, stall_cnt);
      check("mp1_data", d,               32'h0000_0005);
      check("mp1_b0",   32'(b_seen[0]),  32'h80);
      check("mp1_b1",   32'(b_seen[1]),  32'h03);
      run_op(ALU_MPOOL, 5'd13, 32'h80FF_FEFD, 32'h0, d, wrd, cyc, stall_cnt);
      check("mp2_data", d,               32'hFFFF_FFFF);

      // Timeout on element 2: WAIT from cycle 6 for 16 cycles, err in cycle 22.
      hold_elem = 2;
      @(negedge clk);
      bus.issue_valid = 1'b1; bus.issue_ctrl = ALU_VECADD; bus.issue_rd = 5'd4;
      bus.issue_a = 32'h1111_1111; bus.issue_b = 32'h2222_2222;
      @(negedge clk);
      bus.issue_valid = 1'b0;
      cyc = 1; wb_cnt = 0; err_cnt = 0; err_cyc = 0;
      repeat (40) begin
         if (bus.wb_valid === 1'b1) wb_cnt++;
         if (bus.err === 1'b1) begin
            err_cnt++;
            if (err_cnt == 1) begin
               err_cyc = cyc;
               check("tmo_ready", 32'(bus.issue_ready), 32'd1);
               check("tmo_stall", 32'(bus.stall),       32'd0);
            end
         end
         @(negedge clk);
         cyc++;
      end
      check("tmo_err_count", 32'(err_cnt), 32'd1);
      check("tmo_err_cycle", 32'(err_cyc), 32'd22);
      check("tmo_no_wb",     32'(wb_cnt),  32'd0);
      hold_elem = -1;
      run_op(ALU_VECADD, 5'd5, 32'h0102_0304, 32'h1020_3040, d, wrd, cyc, stall_cnt);
      check("post_tmo_data",  d,        32'h1122_3344);
      check("post_tmo_cycle", 32'(cyc), 32'd9);

      // Flush in WAIT of element 1 (cycle 4), coinciding with its result.
      @(negedge clk);
      bus.issue_valid = 1'b1; bus.issue_ctrl = ALU_MATMUL; bus.issue_rd = 5'd6;
      bus.issue_a = 32'h0102_0304; bus.issue_b = 32'h0101_0101;
      @(negedge clk);
      bus.issue_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("fl_busy", 32'(bus.stall), 32'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("fl_stall", 32'(bus.stall),       32'd0);
      check("fl_ready", 32'(bus.issue_ready), 32'd1);
      check("fl_wb",    32'(bus.wb_valid),    32'd0);
      wb_cnt = 0; err_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.wb_valid === 1'b1) wb_cnt++;
         if (bus.err === 1'b1) err_cnt++;
      end
      check("fl_no_wb",  32'(wb_cnt),  32'd0);
      check("fl_no_err", 32'(err_cnt), 32'd0);

      // Reset while in SEND of element 1 (cycle 3).
      bus.issue_valid = 1'b1; bus.issue_ctrl = ALU_RELU; bus.issue_rd = 5'd8;
      bus.issue_a = 32'h0102_0304; bus.issue_b = 32'h0;
      @(negedge clk);
      bus.issue_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rs_in_send", 32'(bus.lane_valid), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rs_stall", 32'(bus.stall),       32'd0);
      check("rs_ready", 32'(bus.issue_ready), 32'd1);
      check("rs_lane",  32'(bus.lane_valid),  32'd0);
      wb_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.wb_valid === 1'b1) wb_cnt++;
      end
      check("rs_no_wb", 32'(wb_cnt), 32'd0);

      // Non-custom ctrl is ignored and never stalls.
      bus.issue_valid = 1'b1; bus.issue_ctrl = 4'h0; bus.issue_rd = 5'd9;
      repeat (3) begin
         @(negedge clk);
         check("bad_ctrl_stall", 32'(bus.stall),       32'd0);
         check("bad_ctrl_ready", 32'(bus.issue_ready), 32'd1);
      end
      bus.issue_valid = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
